// File: rtl/updown_mod_counter.sv
// updown_mod_counter: modulo up/down counter with a runtime-programmable terminal value.
// Features:
//   - synchronous clear and load
//   - AT_MAX and AT_ZERO boundary flags
//   - registered TRIG_OUT pulse for cascading counter stages
// Optional build macro: COUNTER_SATURATE_EN.
//   - When defined, the count stops at its bounds instead of wrapping.
//   - When undefined (the default), the count wraps.
module updown_mod_counter #(
    parameter int                       COUNTER_WIDTH = 8,
    parameter logic [COUNTER_WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     ENABLE_IN,
    input  logic                     DIR,
    input  logic                     CLEAR,
    input  logic                     LOAD,
    input  logic [COUNTER_WIDTH-1:0] LOAD_VALUE,
    input  logic [COUNTER_WIDTH-1:0] MAX_VALUE,
    output logic [COUNTER_WIDTH-1:0] COUNT,
    output logic                     TRIG_OUT,
    output logic                     AT_MAX,
    output logic                     AT_ZERO
);

    logic [COUNTER_WIDTH-1:0] next_count;
    logic                     next_trig;
    logic [COUNTER_WIDTH-1:0] count_plus;
    logic [COUNTER_WIDTH-1:0] count_minus;
    logic                     above_max;
    logic                     at_max_int;
    logic                     at_zero_int;

    // The +1/-1 results are only selected away from the bounds, so they never wrap in COUNTER_WIDTH bits.
    assign count_plus  = COUNT + COUNTER_WIDTH'(1);
    assign count_minus = COUNT - COUNTER_WIDTH'(1);
    assign above_max   = (COUNT > MAX_VALUE);
    assign at_max_int  = (COUNT == MAX_VALUE);
    assign at_zero_int = (COUNT == '0);

    assign AT_MAX  = at_max_int;
    assign AT_ZERO = at_zero_int;

    // Next-state selection in priority order: clear, load, then the enabled step.
    always_comb begin
        next_count = COUNT;
        next_trig  = 1'b0;
        if (CLEAR) begin
            next_count = '0;
        end else if (LOAD) begin
            next_count = (LOAD_VALUE > MAX_VALUE) ? MAX_VALUE : LOAD_VALUE;
        end else if (ENABLE_IN) begin
`ifdef COUNTER_SATURATE_EN
            if (above_max) begin
                next_count = MAX_VALUE;
            end else if (DIR) begin
                if (!at_max_int) begin
                    next_count = count_plus;
                    next_trig  = (count_plus == MAX_VALUE);
                end
            end else begin
                if (!at_zero_int) begin
                    next_count = count_minus;
                    next_trig  = (count_minus == '0);
                end
            end
`else
            if (DIR) begin
                if (above_max || at_max_int) begin
                    next_count = '0;
                    next_trig  = 1'b1;
                end else begin
                    next_count = count_plus;
                end
            end else begin
                if (above_max) begin
                    next_count = MAX_VALUE;
                end else if (at_zero_int) begin
                    next_count = MAX_VALUE;
                    next_trig  = 1'b1;
                end else begin
                    next_count = count_minus;
                end
            end
`endif
        end
    end

    // Register the count and the one-cycle trigger pulse; reset overrides every other control.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            COUNT    <= RESET_VALUE;
            TRIG_OUT <= 1'b0;
        end else begin
            COUNT    <= next_count;
            TRIG_OUT <= next_trig;
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: directed self-checking bench for updown_mod_counter.
// Configuration: 4-bit counter, RESET_VALUE = 0.
// The expected values follow the build: wrap mode by default, saturating mode when COUNTER_SATURATE_EN is defined.
module tb_updown_mod_counter;

    localparam int W = 4;
`ifdef COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         CLK;
    logic         RESET;
    logic         ENABLE_IN;
    logic         DIR;
    logic         CLEAR;
    logic         LOAD;
    logic [W-1:0] LOAD_VALUE;
    logic [W-1:0] MAX_VALUE;
    logic [W-1:0] COUNT;
    logic         TRIG_OUT;
    logic         AT_MAX;
    logic         AT_ZERO;

    int checkCount = 0;
    int passCount  = 0;

    updown_mod_counter #(
        .COUNTER_WIDTH(W),
        .RESET_VALUE  (4'd0)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .ENABLE_IN (ENABLE_IN),
        .DIR       (DIR),
        .CLEAR     (CLEAR),
        .LOAD      (LOAD),
        .LOAD_VALUE(LOAD_VALUE),
        .MAX_VALUE (MAX_VALUE),
        .COUNT     (COUNT),
        .TRIG_OUT  (TRIG_OUT),
        .AT_MAX    (AT_MAX),
        .AT_ZERO   (AT_ZERO)
    );

    // Free-running clock with a 10-time-unit period.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Compares one observed value against its expected value, counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drives one set of inputs, then waits until 1 time unit after the next rising edge.
    task automatic applyStimulus(input logic rst, input logic clr, input logic ld, input int lv,
                                 input logic en, input logic dir, input int maxv);
        RESET      = rst;
        CLEAR      = clr;
        LOAD       = ld;
        LOAD_VALUE = W'(lv);
        ENABLE_IN  = en;
        DIR        = dir;
        MAX_VALUE  = W'(maxv);
        @(posedge CLK);
        #1;
    endtask

    int expCount;
    int expTrig;
    int downWrap[4] = '{1, 0, 9, 8};
    int downSat[4]  = '{1, 0, 0, 0};

    initial begin
        RESET = 1'b1; CLEAR = 1'b0; LOAD = 1'b0; LOAD_VALUE = '0;
        ENABLE_IN = 1'b0; DIR = 1'b1; MAX_VALUE = 4'd9;

        // Reset state.
        applyStimulus(1, 0, 0, 0, 0, 1, 9);
        applyStimulus(1, 0, 0, 0, 1, 1, 9);
        checkOutput("reset_count", COUNT, 0);
        checkOutput("reset_trig", TRIG_OUT, 0);
        checkOutput("reset_at_zero", AT_ZERO, 1);
        checkOutput("reset_at_max", AT_MAX, 0);

        // Count up 11 enabled steps with MAX 9.
        for (int i = 1; i <= 11; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 1, 9);
            expCount = SAT ? ((i < 9) ? i : 9) : (i % 10);
            expTrig  = SAT ? int'(i == 9) : int'(i == 10);
            checkOutput($sformatf("up_count[%0d]", i), COUNT, expCount);
            checkOutput($sformatf("up_trig[%0d]", i), TRIG_OUT, expTrig);
            if (i == 9) checkOutput("at_max_flag", AT_MAX, 1);
        end

        // Load 2 with the step disabled, then hold with the step disabled.
        applyStimulus(0, 0, 1, 2, 0, 1, 9);
        checkOutput("load2_count", COUNT, 2);
        applyStimulus(0, 0, 0, 0, 0, 1, 9);
        checkOutput("hold_count", COUNT, 2);
        checkOutput("hold_trig", TRIG_OUT, 0);

        // Count down from 2 with MAX 9.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 9);
            expCount = SAT ? downSat[i] : downWrap[i];
            expTrig  = SAT ? int'(i == 1) : int'(i == 2);
            checkOutput($sformatf("down_count[%0d]", i), COUNT, expCount);
            checkOutput($sformatf("down_trig[%0d]", i), TRIG_OUT, expTrig);
            if (i == 1) checkOutput("at_zero_flag", AT_ZERO, 1);
        end

        // A load above MAX clamps to MAX, and LOAD wins over ENABLE_IN.
        applyStimulus(0, 0, 1, 12, 1, 1, 9);
        checkOutput("load_clamp_count", COUNT, 9);
        checkOutput("load_clamp_trig", TRIG_OUT, 0);

        // CLEAR at the bound with the step enabled: CLEAR wins and suppresses the trigger.
        applyStimulus(0, 1, 0, 0, 1, 1, 9);
        checkOutput("clear_count", COUNT, 0);
        checkOutput("clear_trig", TRIG_OUT, 0);

        // LOAD and CLEAR together: CLEAR wins.
        applyStimulus(0, 1, 1, 6, 0, 1, 9);
        checkOutput("clear_load_count", COUNT, 0);

        // RESET together with LOAD: RESET wins.
        applyStimulus(0, 0, 1, 5, 0, 1, 9);
        checkOutput("load5_count", COUNT, 5);
        applyStimulus(1, 0, 1, 7, 1, 1, 9);
        checkOutput("reset_load_count", COUNT, 0);

        // COUNT above a lowered MAX, then an up step.
        applyStimulus(0, 0, 1, 7, 0, 1, 9);
        applyStimulus(0, 0, 0, 0, 1, 1, 5);
        checkOutput("above_max_up_count", COUNT, SAT ? 5 : 0);
        checkOutput("above_max_up_trig", TRIG_OUT, SAT ? 0 : 1);

        // COUNT above a lowered MAX, then a down step.
        applyStimulus(0, 0, 1, 7, 0, 1, 9);
        applyStimulus(0, 0, 0, 0, 1, 0, 5);
        checkOutput("above_max_down_count", COUNT, 5);
        checkOutput("above_max_down_trig", TRIG_OUT, 0);

        // MAX 0 with the step enabled, in both directions.
        applyStimulus(0, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 1, (i < 3) ? 1'b1 : 1'b0, 0);
            checkOutput($sformatf("max0_count[%0d]", i), COUNT, 0);
            checkOutput($sformatf("max0_trig[%0d]", i), TRIG_OUT, SAT ? 0 : 1);
        end

        // MAX 3, counting up for six steps from 0.
        applyStimulus(0, 1, 0, 0, 0, 1, 3);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 1, 3);
            expCount = SAT ? ((i < 3) ? i : 3) : (i % 4);
            expTrig  = SAT ? int'(i == 3) : int'(i == 4);
            checkOutput($sformatf("max3_count[%0d]", i), COUNT, expCount);
            checkOutput($sformatf("max3_trig[%0d]", i), TRIG_OUT, expTrig);
        end

        // Disabling the step drops TRIG_OUT.
        applyStimulus(0, 0, 0, 0, 0, 1, 3);
        checkOutput("disable_trig", TRIG_OUT, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
